// File: rtl/packer_pkg.sv
// Shared types and sizing for the byte-to-128-bit-word packer.
package packer_pkg;

    typedef enum logic {FILL, HOLD} packer_state_t;

    localparam int BYTES_PER_WORD = 16;
    localparam int IDX_W          = 4;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream little-endian into 128-bit words, with a
// one-word output register and a HOLD state for full-rate backpressure.
module byte_word_packer
    import packer_pkg::*;
#(
    parameter int WORD_W = 128,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [4:0]        out_nbytes
);

    // Handshakes: a byte moves when in_valid && in_ready, a word moves when
    // out_valid && out_ready; in_ready is a pure decode of the state flop.

    packer_state_t                               state;
    logic [BYTES_PER_WORD-1:0][BYTE_W-1:0]       acc;
    logic [BYTES_PER_WORD-1:0][BYTE_W-1:0]       acc_wr;
    logic [BYTES_PER_WORD-1:0][BYTE_W-1:0]       word_nxt;
    logic [IDX_W-1:0]                            idx;
    logic [4:0]                                  len_q;
    logic [4:0]                                  len_nxt;
    logic                                        accept;
    logic                                        completing;
    logic                                        slot_free;

    assign in_ready   = (state == FILL);
    assign accept     = in_valid && in_ready;
    assign completing = accept && ((idx == IDX_W'(BYTES_PER_WORD - 1)) || in_last);
    assign slot_free  = !out_valid || out_ready;
    assign len_nxt    = {1'b0, idx} + 5'd1;

    // acc_wr: accumulator with the incoming lane written.
    // word_nxt: same, but every lane above idx forced to zero.
    always_comb begin
        acc_wr   = acc;
        word_nxt = '0;
        for (logic [IDX_W:0] lane = '0; lane < (IDX_W+1)'(BYTES_PER_WORD); lane++) begin
            if (lane[IDX_W-1:0] == idx) begin
                acc_wr[lane[IDX_W-1:0]]   = in_data;
                word_nxt[lane[IDX_W-1:0]] = in_data;
            end else if (lane < {1'b0, idx}) begin
                word_nxt[lane[IDX_W-1:0]] = acc[lane[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            acc        <= '0;
            idx        <= '0;
            len_q      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_nbytes <= '0;
        end else begin
            // A transfer with no reload drops valid; loads below override this.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                FILL: begin
                    if (accept && !completing) begin
                        acc <= acc_wr;
                        idx <= idx + 1'b1;
                    end else if (completing && slot_free) begin
                        out_data   <= word_nxt;
                        out_nbytes <= len_nxt;
                        out_valid  <= 1'b1;
                        acc        <= '0;
                        idx        <= '0;
                    end else if (completing) begin
                        acc   <= acc_wr;
                        len_q <= len_nxt;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // Lanes above the held length are already zero in acc.
                    if (slot_free) begin
                        out_data   <= acc;
                        out_nbytes <= len_q;
                        out_valid  <= 1'b1;
                        acc        <= '0;
                        idx        <= '0;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench for byte_word_packer: directed scenarios plus random
// traffic, scored against a queue-based model of the packing rules.
module tb_byte_word_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [4:0]   out_nbytes;

    int n_checks = 0;
    int n_pass   = 0;
    int word_cnt = 0;
    int ov_cycles = 0;
    int stall_cnt = 0;

    logic [132:0] exp_q[$];
    logic [7:0]   cur_bytes[$];

    byte_word_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_nbytes (out_nbytes)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model + scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            cur_bytes.delete();
            exp_q.delete();
        end else begin
            if (out_valid) ov_cycles++;
            if (out_valid && out_ready) begin
                word_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 128'd1, 128'd0);
                end else begin
                    logic [132:0] e;
                    e = exp_q.pop_front();
                    check("word_data", out_data, e[127:0]);
                    check("word_nbytes", {123'd0, out_nbytes}, {123'd0, e[132:128]});
                end
            end
            if (in_valid && !in_ready) stall_cnt++;
            if (in_valid && in_ready) begin
                cur_bytes.push_back(in_data);
                if (cur_bytes.size() == 16 || in_last) begin
                    logic [127:0] w;
                    w = '0;
                    for (int k = 0; k < cur_bytes.size(); k++)
                        w = w | (128'(cur_bytes[k]) << (8 * k));
                    exp_q.push_back({5'(cur_bytes.size()), w});
                    cur_bytes.delete();
                end
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready && waited < 200) begin
            tick(1);
            waited++;
            if (waited > 3 && out_ready === 1'b0 && $urandom_range(0, 1) == 1) out_ready = 1'b1;
        end
        if (!in_ready) check("in_ready_timeout", 128'd0, 128'd1);
        tick(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_nbytes", {123'd0, out_nbytes}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int w0, s0, o0;
        tick(2);
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_out_data", out_data, 128'd0);
        check("reset_out_nbytes", {123'd0, out_nbytes}, 128'd0);
        check("reset_in_ready", {127'd0, in_ready}, 128'd1);
        rst = 1'b0;
        tick(1);

        // Full word 0x00..0x0F
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        check("full_valid", {127'd0, out_valid}, 128'd1);
        check("full_data", out_data, 128'h0F0E0D0C0B0A09080706050403020100);
        check("full_nbytes", {123'd0, out_nbytes}, 128'd16);

        // Short word flushed by in_last
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        check("short_valid", {127'd0, out_valid}, 128'd1);
        check("short_data", out_data, 128'h0000_0000_0000_0000_0000_0000_0000_BBAA);
        check("short_nbytes", {123'd0, out_nbytes}, 128'd2);
        tick(2);

        // Backpressure: two words, second stuck in HOLD
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        check("hold_in_ready", {127'd0, in_ready}, 128'd0);
        check("hold_out_valid", {127'd0, out_valid}, 128'd1);
        tick(3);
        check("hold_stays", {127'd0, in_ready}, 128'd0);
        w0 = word_cnt;
        out_ready = 1'b1;
        tick(1);
        check("hold_release_ready", {127'd0, in_ready}, 128'd1);
        tick(2);
        check("hold_two_words", 128'(word_cnt - w0), 128'd2);

        // Back-to-back 48 bytes
        w0 = word_cnt; s0 = stall_cnt; o0 = ov_cycles;
        for (int i = 0; i < 48; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        tick(2);
        check("b2b_words", 128'(word_cnt - w0), 128'd3);
        check("b2b_stalls", 128'(stall_cnt - s0), 128'd0);
        check("b2b_valid_cycles", 128'(ov_cycles - o0), 128'd3);

        // Async reset mid-word, then a clean word
        for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        async_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1'b0);
        check("post_rst_data", out_data, 128'h4F4E4D4C4B4A49484746454443424140);
        tick(2);

        // Async reset while in HOLD
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        check("hold2_in_ready", {127'd0, in_ready}, 128'd0);
        async_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b0);
        check("post_hold_rst_data", out_data, 128'h8F8E8D8C8B8A89888786858483828180);
        tick(2);

        // in_last on the 16th byte: exactly one word
        w0 = word_cnt;
        for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), i == 15);
        tick(3);
        check("last16_words", 128'(word_cnt - w0), 128'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                in_last = 1'b1;  // no byte offered: must be ignored
                tick(1);
                in_last = 1'b0;
            end
            send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
        end

        // Drain
        send_byte(8'h5A, 1'b1);
        out_ready = 1'b1;
        tick(4);
        check("drain_empty", 128'(exp_q.size()), 128'd0);
        check("drain_out_valid", {127'd0, out_valid}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
